// File: rtl/mips_display_pkg.sv
// Shared constants and types for the register display driver.
package mips_display_pkg;

  // Active-low {g,f,e,d,c,b,a} with every segment off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low hex font. Entry 0 is the least significant slice.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Push-button debounce states.
  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_HELD         = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_e;

  // Segment pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/reg_display_driver_btn_debounce.sv
// Synchronises a raw push-button and emits one step pulse per accepted press.
module btn_debounce
  import mips_display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic reset,
  input  logic raw,
  output logic step
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             btn_s_q;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             step_q;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      btn_s_q <= sync1_q;
    end
  end

  // Press/release qualification; a press is only re-armed after a stable release.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        DB_IDLE: begin
          if (btn_s_q) begin
            state_q <= DB_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        DB_PRESS_WAIT: begin
          if (!btn_s_q) begin
            state_q <= DB_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_HELD;
            step_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DB_HELD: begin
          if (!btn_s_q) begin
            state_q <= DB_RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        DB_RELEASE_WAIT: begin
          if (btn_s_q) begin
            state_q <= DB_HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= DB_IDLE;
      endcase
    end
  end

  assign step = step_q;

endmodule

// File: rtl/reg_display_driver.sv
// Multiplexed 4-digit display of the core's register byte and address,
// plus the button-driven byte selector fed back to the core.
module reg_display_driver
  import mips_display_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES    = 25000,
  parameter int unsigned BLANK_CYCLES    = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] reg_byte,
  input  logic [4:0] user_addr,
  input  logic       btn_next,
  output logic [1:0] reg_bits,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYCLES);

  logic              step;
  logic [1:0]        reg_bits_q;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        idx_q;
  logic [7:0]        snap_byte_q;
  logic [4:0]        snap_addr_q;
  logic [3:0]        nib_c;
  logic              blank_c;
  logic [6:0]        seg_q;
  logic [3:0]        an_q;
  logic              dp_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .CLK  (CLK),
    .reset(reset),
    .raw  (btn_next),
    .step (step)
  );

  // Byte selector advances once per accepted press, wrapping 3 -> 0.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      reg_bits_q <= 2'd0;
    end else if (step) begin
      reg_bits_q <= reg_bits_q + 2'd1;
    end
  end

  // Slot timer and digit index; inputs are sampled only at scan wrap so a scan never tears.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      slot_q      <= '0;
      idx_q       <= 2'd0;
      snap_byte_q <= 8'd0;
      snap_addr_q <= 5'd0;
    end else if (slot_q == SLOT_LAST) begin
      slot_q <= '0;
      idx_q  <= idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        snap_byte_q <= reg_byte;
        snap_addr_q <= user_addr;
      end
    end else begin
      slot_q <= slot_q + SLOT_W'(1);
    end
  end

  // Nibble shown in the current slot.
  always_comb begin
    nib_c = 4'd0;
    case (idx_q)
      2'd0:    nib_c = snap_byte_q[3:0];
      2'd1:    nib_c = snap_byte_q[7:4];
      2'd2:    nib_c = snap_addr_q[3:0];
      default: nib_c = {3'b000, snap_addr_q[4]};
    endcase
  end

  assign blank_c = (slot_q < SLOT_BLANK);

  // Registered display drive; all anodes off for the first clocks of each slot.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_BLANK;
      an_q  <= 4'hF;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= blank_c ? SEG_BLANK : hex_to_seg(nib_c);
      an_q  <= blank_c ? 4'hF : ~(4'b0001 << idx_q);
      dp_q  <= blank_c | (idx_q != reg_bits_q);
    end
  end

  assign reg_bits = reg_bits_q;
  assign seg      = seg_q;
  assign an       = an_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_reg_display_driver.sv
// Scoreboard bench for reg_display_driver with short scan/debounce periods.
module tb_reg_display_driver;

  localparam int unsigned DC   = 8;
  localparam int unsigned BC   = 2;
  localparam int unsigned DB   = 16;
  localparam int unsigned SCAN = 4 * DC;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         dp_chk;
  } disp_t;

  typedef struct {
    logic [1:0] val;
    int         press_cyc;
  } rb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] reg_byte = 8'd0;
  logic [4:0] user_addr = 5'd0;
  logic       btn = 1'b0;
  logic [1:0] reg_bits;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  disp_t exp_q[$];
  rb_t   rb_q[$];
  logic [1:0] rb_model = 2'd0;
  bit         rb_settled = 1'b1;

  reg_display_driver #(
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLK(clk),
    .reset(rst_n),
    .reg_byte(reg_byte),
    .user_addr(user_addr),
    .btn_next(btn),
    .reg_bits(reg_bits),
    .seg(seg),
    .an(an),
    .dp(dp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the display is a pure function of clocks since reset and
  // of the inputs seen at each whole-scan boundary.
  int         n = 0;
  logic [7:0] m_byte = 8'd0;
  logic [4:0] m_addr = 5'd0;
  always @(posedge clk) begin
    int pos, slot, idx;
    logic [3:0] nib;
    disp_t me;
    if (!rst_n) begin
      n = 0;
      m_byte = 8'd0;
      m_addr = 5'd0;
      exp_q.delete();
    end else begin
      n++;
      pos  = n - 1;
      slot = pos % DC;
      idx  = (pos / DC) % 4;
      case (idx)
        0: nib = m_byte[3:0];
        1: nib = m_byte[7:4];
        2: nib = m_addr[3:0];
        default: nib = {3'b000, m_addr[4]};
      endcase
      me.an     = (slot < BC) ? 4'hF : (4'hF ^ (4'(1) << idx));
      me.seg    = font(nib);
      me.dp     = (slot < BC) ? 1'b1 : ((idx == int'(rb_model)) ? 1'b0 : 1'b1);
      me.dp_chk = (slot < BC) || rb_settled;
      exp_q.push_back(me);
      if (n % SCAN == 0) begin
        m_byte = reg_byte;
        m_addr = user_addr;
      end
    end
  end

  // Monitor: compare display every clock and every selector change.
  logic [1:0] prev_rb = 2'd0;
  always @(negedge clk) begin
    disp_t ce;
    rb_t   cr;
    if (!rst_n) begin
      prev_rb = 2'd0;
    end else begin
      if (exp_q.size() > 0) begin
        ce = exp_q.pop_front();
        chk("an", int'(an), int'(ce.an));
        if (ce.an != 4'hF) chk("seg", int'(seg), int'(ce.seg));
        if (ce.dp_chk) chk("dp", int'(dp), int'(ce.dp));
      end
      if (reg_bits != prev_rb) begin
        if (rb_q.size() == 0) begin
          chk("rb_unexpected_step", int'(reg_bits), int'(prev_rb));
        end else begin
          cr = rb_q.pop_front();
          chk("rb_step_value", int'(reg_bits), int'(cr.val));
          checks++;
          if ((cyc - cr.press_cyc) < int'(DB + 2) || (cyc - cr.press_cyc) > int'(DB + 7)) begin
            errors++;
            $display("FAIL rb_step_latency: got %0d clocks expected %0d..%0d", cyc - cr.press_cyc, DB + 2, DB + 7);
          end
        end
        prev_rb = reg_bits;
      end
    end
  end

  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  // Short random glitches that never stay stable long enough to count.
  task automatic glitch(input int toggles, input int fixed_len);
    for (int i = 0; i < toggles; i++) begin
      btn = ~btn;
      wait_cyc((fixed_len > 0) ? fixed_len : int'($urandom_range(1, 5)));
    end
    btn = 1'b0;
    wait_cyc(1);
  endtask

  // One press that the model accepts: optional bounce, stable hold, bouncy release.
  task automatic press(input int bounce, input int bounce_len, input int hold, input int rel_bounce, input int rel);
    rb_t r;
    rb_settled = 1'b0;
    if (bounce > 0) glitch(bounce, bounce_len);
    btn = 1'b1;
    r.val = rb_model + 2'd1;
    r.press_cyc = cyc;
    rb_q.push_back(r);
    wait_cyc(hold);
    for (int i = 0; i < rel_bounce; i++) begin
      btn = ~btn;
      wait_cyc(int'($urandom_range(1, 5)));
    end
    btn = 1'b0;
    wait_cyc(rel);
    rb_model = rb_model + 2'd1;
    rb_settled = 1'b1;
    chk("rb_after_press", int'(reg_bits), int'(rb_model));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_seg", int'(seg), 'h7F);
    chk("rst_an", int'(an), 'hF);
    chk("rst_dp", int'(dp), 1);
    chk("rst_reg_bits", int'(reg_bits), 0);
    #1 rst_n = 1'b1;
    wait_cyc(SCAN);

    // Known byte/address shown on the following scan.
    reg_byte = 8'hA5;
    user_addr = 5'h13;
    wait_cyc(2 * SCAN);

    // Change the byte while the second digit is showing.
    for (int i = 0; i < int'(SCAN) && ((n / DC) % 4) != 1; i++) wait_cyc(1);
    reg_byte = 8'h3C;
    wait_cyc(2 * SCAN);

    // Clean press, then a bouncy press, then rejected glitches.
    press(0, 0, 25, 0, 40);
    press(10, 3, 25, 0, 40);
    glitch(12, 0);
    wait_cyc(30);
    chk("rb_after_glitch", int'(reg_bits), int'(rb_model));

    // Four more presses walk the selector round and back.
    for (int i = 0; i < 4; i++) begin
      reg_byte = 8'($urandom);
      user_addr = 5'($urandom);
      press(int'($urandom_range(0, 6)), 0, int'($urandom_range(20, 40)),
            int'($urandom_range(0, 4)), int'($urandom_range(25, 40)));
    end

    // Reset in the middle of a press, released with the button still down.
    rb_settled = 1'b0;
    btn = 1'b1;
    wait_cyc(10);
    rst_n = 1'b0;
    rb_q.delete();
    rb_model = 2'd0;
    wait_cyc(3);
    chk("rst_mid_reg_bits", int'(reg_bits), 0);
    chk("rst_mid_an", int'(an), 'hF);
    begin
      rb_t r;
      r.val = 2'd1;
      r.press_cyc = cyc;
      rst_n = 1'b1;
      rb_q.push_back(r);
    end
    wait_cyc(30);
    btn = 1'b0;
    wait_cyc(40);
    rb_model = 2'd1;
    rb_settled = 1'b1;
    chk("rb_after_reset_press", int'(reg_bits), 1);

    // Random display content with occasional presses.
    for (int i = 0; i < 6; i++) begin
      reg_byte = 8'($urandom);
      user_addr = 5'($urandom);
      wait_cyc(int'($urandom_range(5, 2 * SCAN)));
      if ($urandom_range(0, 1) == 1) press(0, 0, int'($urandom_range(20, 30)), 0, 30);
    end

    wait_cyc(2 * SCAN);
    chk("rb_queue_drained", rb_q.size(), 0);
    chk("rb_final", int'(reg_bits), int'(rb_model));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
